// File: rtl/reg_scoreboard.sv
// Outstanding-write scoreboard for the integer register file: per-register saturating
// in-flight write counts, RAW/saturation hazard check at issue, and writeback bypass.
module reg_scoreboard #(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 2,
    parameter int TOT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic              issue_re1,
    input  logic [ADDR_W-1:0] issue_rs1,
    input  logic              issue_re2,
    input  logic [ADDR_W-1:0] issue_rs2,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ready,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic [TOT_W-1:0]  pending_total,
    output logic              err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]   cnt_all [REG_NUM];
    logic [REG_NUM-1:0] uf_vec;

    logic               accept;
    logic               wb_eff;
    logic [CNT_W-1:0]   rs1_cnt, rs2_cnt, rd_cnt, wb_cnt;
    logic               rs1_blocked, rs2_blocked, rd_saturated;
    logic               same_reg;
    logic               inc_eff, dec_eff;

    logic [TOT_W-1:0]   total_reg, total_next;
    logic               err_reg;

    // Writebacks only take effect when the pipeline is advancing and not being flushed.
    assign wb_eff = rdy && !flush && wb_valid && (wb_addr != '0);

    assign rs1_cnt = cnt_all[issue_rs1];
    assign rs2_cnt = cnt_all[issue_rs2];
    assign rd_cnt  = cnt_all[issue_rd];
    assign wb_cnt  = cnt_all[wb_addr];

    // A single remaining write completing this cycle is forwarded by the register file.
    always_comb begin
        rs1_blocked = 1'b0;
        rs2_blocked = 1'b0;
        rd_saturated = 1'b0;
        if (issue_re1 && (issue_rs1 != '0)) begin
            rs1_blocked = (rs1_cnt > CNT_ONE) ||
                          ((rs1_cnt == CNT_ONE) && !(wb_valid && (wb_addr == issue_rs1)));
        end
        if (issue_re2 && (issue_rs2 != '0)) begin
            rs2_blocked = (rs2_cnt > CNT_ONE) ||
                          ((rs2_cnt == CNT_ONE) && !(wb_valid && (wb_addr == issue_rs2)));
        end
        if (issue_we && (issue_rd != '0)) begin
            rd_saturated = (rd_cnt == CNT_MAX) && !(wb_valid && (wb_addr == issue_rd));
        end
    end

    assign issue_ready = rdy && !rst && !flush && !rs1_blocked && !rs2_blocked && !rd_saturated;
    assign accept      = issue_valid && issue_ready;

    assign cnt_all[0] = '0;
    assign uf_vec[0]  = 1'b0;

    generate
        for (genvar gi = 1; gi < REG_NUM; gi++) begin : g_reg
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic             inc, dec;

            assign inc = accept && issue_we && (issue_rd == ADDR_W'(gi));
            assign dec = wb_eff && (wb_addr == ADDR_W'(gi));

            always_comb begin
                cnt_next = cnt_reg;
                if (inc && !dec) begin
                    cnt_next = cnt_reg + CNT_ONE;
                end else if (dec && !inc && (cnt_reg != '0)) begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (rdy) begin
                    cnt_reg <= flush ? '0 : cnt_next;
                end
            end

            assign cnt_all[gi] = cnt_reg;
            assign uf_vec[gi]  = dec && !inc && (cnt_reg == '0);
        end
    endgenerate

    // Running total tracks the count deltas; simultaneous inc/dec of one register cancels.
    assign same_reg = accept && issue_we && wb_eff && (issue_rd == wb_addr);
    assign inc_eff  = accept && issue_we && (issue_rd != '0) && !same_reg;
    assign dec_eff  = wb_eff && !same_reg && (wb_cnt != '0);

    always_comb begin
        total_next = total_reg;
        if (inc_eff && !dec_eff) begin
            total_next = total_reg + TOT_W'(1);
        end else if (dec_eff && !inc_eff) begin
            total_next = total_reg - TOT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total_reg <= '0;
            err_reg   <= 1'b0;
        end else if (rdy) begin
            total_reg <= flush ? '0 : total_next;
            err_reg   <= err_reg | (|uf_vec);
        end
    end

    assign pending_total = total_reg;
    assign err           = err_reg;

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Tracks outstanding register writes for the integer register file so issue logic never reads an operand whose producer has not yet written back. Per architectural register it holds a saturating count of in-flight writes; issue consults it and increments, writeback decrements. Sits between decode/issue and the register-file write port. Its bypass rule matches the register file's write-through read: data written in the current cycle is readable in the same cycle.

## Interface

- REG_NUM, 32, number of architectural registers; register 0 is hardwired zero.
- ADDR_W, 5, register address width; log2(REG_NUM).
- CNT_W, 2, per-register outstanding-write counter width; maximum outstanding writes per register is 2^CNT_W-1.
- TOT_W, 8, width of pending_total.

- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- rdy  input  1  global ready; when low, all state holds and issue_ready=0.
- flush  input  1  pipeline flush; clears all counts at the next edge.
- issue_valid  input  1  the instruction at issue is valid.
- issue_re1  input  1  the instruction reads rs1.
- issue_rs1  input  ADDR_W  rs1 address.
- issue_re2  input  1  the instruction reads rs2.
- issue_rs2  input  ADDR_W  rs2 address.
- issue_we  input  1  the instruction writes rd.
- issue_rd  input  ADDR_W  rd address.
- issue_ready  output  1  combinational; the issue can be accepted this cycle.
- wb_valid  input  1  writeback to the register file this cycle.
- wb_addr  input  ADDR_W  writeback register.
- pending_total  output  TOT_W  registered sum of all per-register counts.
- err  output  1  sticky; set on writeback underflow.

## Operation

- State: cnt[r] for r=1..REG_NUM-1. cnt[0] does not exist and always reads 0.
- Hazard rule for a source s (s = rs1 or rs2, with its read enable high and s != 0):
  - s is blocked if cnt[s] > 1.
  - s is blocked if cnt[s] == 1 and not (wb_valid && wb_addr == s).
  - This is the writeback bypass: the final pending write to s completing this cycle is forwarded by the register file.
- Saturation rule: the issue is blocked if issue_we && issue_rd != 0 && cnt[rd] == max && not (wb_valid && wb_addr == rd).
- issue_ready = rdy && !rst && !flush && no blocked source && no saturation. It does not depend on issue_valid.
- accept = issue_valid && issue_ready.
- Per-register update, with inc = accept && issue_we && issue_rd == r && r != 0, and dec = wb_valid && wb_addr == r && r != 0:
  - inc only: cnt + 1.
  - dec only, cnt > 0: cnt - 1.
  - both: unchanged.
  - dec only, cnt == 0: unchanged, and err is set to 1.
- A writeback to address 0 is ignored and does not set err.
- flush (with rdy high): all cnt = 0 at the next edge. A same-cycle issue and writeback are discarded, and no err is raised that cycle.
- pending_total is registered and equals the sum of the post-update counts. It is maintained incrementally: +1 on inc, -1 on dec, 0 on both or on underflow, and 0 after flush.
- rdy low: cnt, pending_total and err hold; wb_valid is ignored.

## Timing

- Reset (synchronous): all cnt=0, pending_total=0, err=0.
- issue_ready is combinational from the current cnt, the issue addresses and wb_*. There is no added latency.
- Counts update at the posedge after accept or writeback. An issue accepted in cycle N makes rd blocked for a dependent issue in cycle N+1.
- A writeback in cycle N unblocks a dependent issue in that same cycle N, through the bypass.
- rst takes priority over flush, and flush takes priority over issue and writeback. Reset mid-operation discards every count.

## Test plan

- Reset, then issue with rd=5, then in the next cycle issue with rs1=5 -> first is accepted, pending_total=1, second has issue_ready=0; wb_addr=5 in that cycle -> issue_ready=1 the same cycle, and pending_total ends at 1 (new rd counted only if issue_we).
- Issue rd=0 and rs1=0 repeatedly -> always ready, pending_total stays 0, err=0.
- With CNT_W=2, issue rd=7 three times -> fourth issue to rd=7 blocked; the same cycle with wb_addr=7 -> accepted, cnt[7] stays 3.
- Issue rd=3 and wb_addr=3 simultaneously with cnt[3]=1 -> cnt[3] stays 1, pending_total unchanged.
- wb_valid with wb_addr=9 and cnt[9]=0 -> err=1 and stays 1 until rst; pending_total unchanged.
- Fill 4 registers, then assert flush together with an issue -> issue_ready=0 that cycle; next cycle all counts 0, pending_total=0. Hold rdy=0 with wb_valid -> no state change.
